staff_overlay_gen: RTL
======================

Name: staff_overlay_gen

Overview:
- Generates the 2-bit staff overlay code consumed by the downstream video mux on its staff pixel input. Values: 0 = transparent, 1 = staff line, 2 = note head, 3 = cursor.
- Holds a circular table of recognised notes. Notes are written by the note-detection logic at any time.
- The table is committed to a display copy only at frame start, so the image never tears.
- Renders five staff lines, one note head per slot, and a cursor on the newest slot. Output is a fixed 2-cycle pipeline from hcount/vcount.

Parameters:
- NUM_NOTES, 16, number of note slots; power of 2.
- X_START, 64, left x of the staff.
- NOTE_WIDTH, 32, slot width in px; power of 2.
- STAFF_TOP, 200, y of the top staff line.
- LINE_SPACING, 16, vertical distance between lines; even.
- HEAD_R, 4, note-head half-height in px.

Ports:
- clk_in  in  1  pixel clock.
- rst_in  in  1  synchronous reset, active-high.
- hcount_in  in  11  current pixel x.
- vcount_in  in  10  current pixel y.
- new_frame_in  in  1  single-cycle pulse at frame start; commit strobe.
- note_valid_in  in  1  write one note this cycle.
- note_pitch_in  in  4  staff position 0..15; 0 = bottom line, each step = LINE_SPACING/2 upward.
- note_rest_in  in  1  the note is a rest: slot is occupied but no head is drawn.
- clear_in  in  1  empty the shadow table.
- note_count_out  out  $clog2(NUM_NOTES)+1  occupied shadow slots.
- staff_pixel_out  out  2  overlay code, 2 cycles after hcount_in/vcount_in.

Behaviour:

Reset (rst_in high at a clock edge) clears:
- all shadow and display slots (empty);
- wr_ptr, note_count_out, the pipeline registers and staff_pixel_out, all to 0.
- Reset mid-frame: the output is 0 for 2 cycles, then only lines are drawn.

Shadow table (write side):
- note_valid_in=1 stores {occupied=1, rest, pitch} at wr_ptr.
- wr_ptr increments and wraps NUM_NOTES-1 → 0, overwriting the oldest slot.
- note_count_out increments, saturating at NUM_NOTES.
- Write side is always ready; there is no backpressure.
- clear_in=1 empties all slots and zeroes wr_ptr and count. If a write arrives in the same cycle as clear_in, clear wins and the write is dropped.

Commit:
- On new_frame_in=1, the display table and display cursor take the shadow state as registered before this edge.
- A write in the same cycle as new_frame_in lands in the shadow only; it becomes visible at the following frame.
- Display cursor = (wr_ptr-1) mod NUM_NOTES. The cursor is enabled only if count > 0.

Pipeline stage 1 (registered):
- in_x = X_START ≤ hcount < X_START + NUM_NOTES*NOTE_WIDTH.
- slot = (hcount - X_START) >> log2(NOTE_WIDTH).
- xoff = low bits of (hcount - X_START).
- dy = vcount - STAFF_TOP, signed, 11 bits.

Pipeline stage 2 (registered output), in priority order:
- cursor (3): in_x, slot = display cursor, cursor enabled, xoff < 2, 0 ≤ dy ≤ 4*LINE_SPACING.
- note (2): in_x, slot occupied and not a rest, NOTE_WIDTH/4 ≤ xoff < 3*NOTE_WIDTH/4, |vcount - cy| ≤ HEAD_R, where cy = STAFF_TOP + 4*LINE_SPACING - pitch*LINE_SPACING/2.
  - Pitches 9..15 draw above the staff and are allowed.
  - cy is computed signed; a negative cy never matches.
- line (1): in_x, dy mod LINE_SPACING = 0, 0 ≤ dy ≤ 4*LINE_SPACING.
- otherwise 0.
- Latency is exactly 2 cycles for all inputs. There is no stall input. Upstream delays its own pixel data by 2 to stay aligned.

Test Plan:
1. Reset, then hcount=100, vcount=216 → staff_pixel_out=1 two cycles later. vcount=217 → 0. hcount=576, vcount=216 → 0, because x is out of range.
2. Write pitch 4 (cy=232) without new_frame_in; hcount=80, vcount=232 → 1. Pulse new_frame_in; same pixel → 2. hcount=64 → 3 (cursor on slot 0). note_count_out=1.
3. Write 17 notes, pitches 0..15 then 7; commit → note_count_out=16, cursor on slot 0. hcount=80, vcount=208 → 2. vcount=264 → 1, because the old pitch-0 head was overwritten.
4. clear_in and note_valid_in in the same cycle, then commit → note_count_out=0. hcount=64, vcount=232 → 1, with no cursor.
5. Pitch 15 (cy=144) committed; hcount=80: vcount=144 → 2, vcount=148 → 2, vcount=149 → 0, vcount=140 → 2.
6. Slot 0 pitch 2, then slot 1 rest, then commit. hcount=112, vcount=248 → 1, because the rest draws no head. hcount=96, vcount=240 → 3, the cursor on slot 1. A write coincident with new_frame_in is not visible until the next new_frame_in.

Source files
------------

// File: rtl/staff_overlay_gen.sv
// Staff overlay generator: circular note table with frame-synchronous commit,
// rendering staff lines, note heads and a cursor through a fixed 2-cycle pipeline.
module staff_overlay_gen #(
  parameter int NUM_NOTES    = 16,
  parameter int X_START      = 64,
  parameter int NOTE_WIDTH   = 32,
  parameter int STAFF_TOP    = 200,
  parameter int LINE_SPACING = 16,
  parameter int HEAD_R       = 4
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [10:0]                  hcount_in,
  input  logic [9:0]                   vcount_in,
  input  logic                         new_frame_in,
  input  logic                         note_valid_in,
  input  logic [3:0]                   note_pitch_in,
  input  logic                         note_rest_in,
  input  logic                         clear_in,
  output logic [$clog2(NUM_NOTES):0]   note_count_out,
  output logic [1:0]                   staff_pixel_out
);

  localparam int SLOT_W  = $clog2(NUM_NOTES);
  localparam int XOFF_W  = $clog2(NOTE_WIDTH);
  localparam int CNT_W   = SLOT_W + 1;
  localparam int X_END   = X_START + NUM_NOTES * NOTE_WIDTH;
  localparam int STAFF_H = 4 * LINE_SPACING;

  // Shadow table (written by note detection) and display table (frame copy)
  logic [NUM_NOTES-1:0] occ_q, rest_q;
  logic [3:0]           pitch_q [NUM_NOTES];
  logic [SLOT_W-1:0]    wr_ptr_q;
  logic [CNT_W-1:0]     count_q;

  logic [NUM_NOTES-1:0] disp_occ_q, disp_rest_q;
  logic [3:0]           disp_pitch_q [NUM_NOTES];
  logic [SLOT_W-1:0]    disp_cursor_q;
  logic                 disp_cur_en_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      occ_q         <= '0;
      rest_q        <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      disp_occ_q    <= '0;
      disp_rest_q   <= '0;
      disp_cursor_q <= '0;
      disp_cur_en_q <= 1'b0;
      for (int i = 0; i < NUM_NOTES; i++) begin
        pitch_q[i]      <= '0;
        disp_pitch_q[i] <= '0;
      end
    end else begin
      if (clear_in) begin
        occ_q    <= '0;
        rest_q   <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else if (note_valid_in) begin
        occ_q[wr_ptr_q]   <= 1'b1;
        rest_q[wr_ptr_q]  <= note_rest_in;
        pitch_q[wr_ptr_q] <= note_pitch_in;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
        if (count_q != CNT_W'(NUM_NOTES)) count_q <= count_q + 1'b1;
      end
      // Commit samples the pre-edge shadow, so a coincident write waits a frame
      if (new_frame_in) begin
        disp_occ_q    <= occ_q;
        disp_rest_q   <= rest_q;
        disp_pitch_q  <= pitch_q;
        disp_cursor_q <= wr_ptr_q - 1'b1;
        disp_cur_en_q <= (count_q != '0);
      end
    end
  end

  assign note_count_out = count_q;

  // Stage 1: screen coordinates relative to the staff origin
  logic [SLOT_W+XOFF_W-1:0] hx_d;
  logic                     in_x_d;
  logic signed [10:0]       dy_d;

  always_comb begin
    hx_d   = (SLOT_W + XOFF_W)'(hcount_in - 11'(X_START));
    in_x_d = (int'(hcount_in) >= X_START) && (int'(hcount_in) < X_END);
    dy_d   = 11'({1'b0, vcount_in}) - 11'(STAFF_TOP);
  end

  logic                 in_x_q;
  logic [SLOT_W-1:0]    slot_q;
  logic [XOFF_W-1:0]    xoff_q;
  logic signed [10:0]   dy_q;
  logic [9:0]           vcount_s1_q;
  logic [1:0]           pix_q;

  // Stage 2: priority cursor > note head > staff line > transparent
  logic signed [12:0] cy, vdiff;
  logic               dy_in_staff, on_line, cursor_hit, note_hit;
  logic [1:0]         pix_d;

  always_comb begin
    cy = 13'(STAFF_TOP + STAFF_H) -
         13'(int'(disp_pitch_q[slot_q]) * (LINE_SPACING / 2));
    vdiff       = 13'({3'b0, vcount_s1_q}) - cy;
    dy_in_staff = (int'(dy_q) >= 0) && (int'(dy_q) <= STAFF_H);
    on_line     = in_x_q && dy_in_staff && ((int'(dy_q) % LINE_SPACING) == 0);
    cursor_hit  = in_x_q && disp_cur_en_q && (slot_q == disp_cursor_q) &&
                  (int'(xoff_q) < 2) && dy_in_staff;
    note_hit    = in_x_q && disp_occ_q[slot_q] && !disp_rest_q[slot_q] &&
                  (int'(xoff_q) >= NOTE_WIDTH / 4) &&
                  (int'(xoff_q) < 3 * NOTE_WIDTH / 4) &&
                  (int'(cy) >= 0) &&
                  (int'(vdiff) >= -HEAD_R) && (int'(vdiff) <= HEAD_R);
    pix_d = 2'd0;
    if (cursor_hit)    pix_d = 2'd3;
    else if (note_hit) pix_d = 2'd2;
    else if (on_line)  pix_d = 2'd1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      in_x_q      <= 1'b0;
      slot_q      <= '0;
      xoff_q      <= '0;
      dy_q        <= '0;
      vcount_s1_q <= '0;
      pix_q       <= 2'd0;
    end else begin
      in_x_q      <= in_x_d;
      slot_q      <= hx_d[XOFF_W +: SLOT_W];
      xoff_q      <= hx_d[XOFF_W-1:0];
      dy_q        <= dy_d;
      vcount_s1_q <= vcount_in;
      pix_q       <= pix_d;
    end
  end

  assign staff_pixel_out = pix_q;

endmodule
